core_pipe_exec_mdu_issue: RTL and testbench

Issue-side controller for the iterative multiply/divide unit. It sits between the execute-stage pipeline and the MDU, and performs four jobs:
- accepts one request at a time over a valid/ready handshake;
- drives a stable MDU request until the MDU reports completion;
- captures the result and re-arms the MDU with a one-cycle flush;
- presents the result to writeback over a second valid/ready handshake.

It also owns pipeline flush, a completion watchdog, and an optional last-result cache.

---
 rtl/core_pipe_exec_mdu_issue.sv | 219 +++++++++++++++++++++
 tb/tb_core_pipe_exec_mdu_issue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_pipe_exec_mdu_issue.sv
`default_nettype none
// ============================================================================
// Module  : core_pipe_exec_mdu_issue
// Brief   : Issue controller for the iterative MDU with watchdog, pipeline
//           flush and optional last-result cache (MDU_ISSUE_RESULT_CACHE_EN).
// Revision: 1.0 - initial release
// ============================================================================
module core_pipe_exec_mdu_issue #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 96
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  output logic            g_clk_req,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [9:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_tag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_tag,
  output logic            rsp_err,
  output logic            mdu_valid,
  output logic [9:0]      mdu_op,
  output logic            mdu_word,
  output logic [XLEN-1:0] mdu_rs1,
  output logic [XLEN-1:0] mdu_rs2,
  output logic            mdu_flush,
  input  logic            mdu_ready,
  input  logic [XLEN-1:0] mdu_rd,
  output logic            err_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam int               WDOG_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] C_WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [9:0]        op_q, op_d;
  logic              word_q, word_d;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
  logic [4:0]        tag_q, tag_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;

  logic w_onehot;
  logic w_issue;
  logic w_timeout;
  logic w_hit;

  assign w_onehot  = (req_op != 10'd0) && ((req_op & (req_op - 10'd1)) == 10'd0);
  assign w_issue   = (state_q == S_ISSUE);
  assign w_timeout = w_issue && !mdu_ready && (wdog_q == C_WDOG_LAST);

`ifdef MDU_ISSUE_RESULT_CACHE_EN
  logic            cvld_q, cvld_d;
  logic [9:0]      cop_q, cop_d;
  logic            cword_q, cword_d;
  logic [XLEN-1:0] crs1_q, crs1_d, crs2_q, crs2_d, cres_q, cres_d;

  assign w_hit = cvld_q && (req_op == cop_q) && (req_word == cword_q) &&
                 (req_rs1 == crs1_q) && (req_rs2 == crs2_q);
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    op_d    = op_q;
    word_d  = word_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
`ifdef MDU_ISSUE_RESULT_CACHE_EN
    cvld_d  = cvld_q;
    cop_d   = cop_q;
    cword_d = cword_q;
    crs1_d  = crs1_q;
    crs2_d  = crs2_q;
    cres_d  = cres_q;
`endif
    // flush outranks every other event, including a same-cycle completion
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_d   = req_op;
            word_d = req_word;
            rs1_d  = req_rs1;
            rs2_d  = req_rs2;
            tag_d  = req_tag;
            wdog_d = '0;
            if (!w_onehot) begin
              state_d = S_RESP;
              err_d   = 1'b1;
              data_d  = '0;
            end else if (w_hit) begin
              state_d = S_RESP;
              err_d   = 1'b0;
`ifdef MDU_ISSUE_RESULT_CACHE_EN
              data_d  = cres_q;
`endif
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wdog_d = wdog_q + WDOG_W'(1);
          if (mdu_ready) begin
            state_d = S_RESP;
            data_d  = mdu_rd;
            err_d   = 1'b0;
`ifdef MDU_ISSUE_RESULT_CACHE_EN
            cvld_d  = 1'b1;
            cop_d   = op_q;
            cword_d = word_q;
            crs1_d  = rs1_q;
            crs2_d  = rs2_q;
            cres_d  = mdu_rd;
`endif
          end else if (w_timeout) begin
            state_d = S_RESP;
            data_d  = '0;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
`ifdef MDU_ISSUE_RESULT_CACHE_EN
            cvld_d  = 1'b0;
`endif
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      wdog_q  <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      op_q    <= op_d;
      word_q  <= word_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef MDU_ISSUE_RESULT_CACHE_EN
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      cvld_q  <= 1'b0;
      cop_q   <= '0;
      cword_q <= 1'b0;
      crs1_q  <= '0;
      crs2_q  <= '0;
      cres_q  <= '0;
    end else begin
      cvld_q  <= cvld_d;
      cop_q   <= cop_d;
      cword_q <= cword_d;
      crs1_q  <= crs1_d;
      crs2_q  <= crs2_d;
      cres_q  <= cres_d;
    end
  end
`endif

  assign req_ready   = (state_q == S_IDLE) && !flush;
  assign g_clk_req   = (state_q != S_IDLE) || req_valid || flush;
  assign mdu_valid   = w_issue;
  assign mdu_flush   = flush || (w_issue && mdu_ready) || w_timeout;
  assign mdu_op      = op_q;
  assign mdu_word    = word_q;
  assign mdu_rs1     = rs1_q;
  assign mdu_rs2     = rs2_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_data    = data_q;
  assign rsp_tag     = tag_q;
  assign rsp_err     = err_q;
  assign err_timeout = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_core_pipe_exec_mdu_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_pipe_exec_mdu_issue
// Brief   : Self-checking bench with a behavioural MDU stub and result model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_core_pipe_exec_mdu_issue;
  localparam int XLEN = 64;
  localparam int TMO  = 96;

  logic            g_clk = 1'b0, g_resetn = 1'b0, flush = 1'b0;
  logic            req_valid = 1'b0, req_word = 1'b0, rsp_ready = 1'b0;
  logic [9:0]      req_op = '0;
  logic [XLEN-1:0] req_rs1 = '0, req_rs2 = '0;
  logic [4:0]      req_tag = '0;
  logic            g_clk_req, req_ready, rsp_valid, rsp_err, mdu_valid, mdu_word;
  logic            mdu_flush, err_timeout, mdu_ready;
  logic [XLEN-1:0] rsp_data, mdu_rs1, mdu_rs2, mdu_rd;
  logic [4:0]      rsp_tag;
  logic [9:0]      mdu_op;

  int n_checks = 0, n_pass = 0;
  int stub_lat = 1, stub_cnt;
  bit stub_hang = 1'b0;
  logic stub_busy;

  logic [XLEN-1:0] r_data;
  logic            r_err;
  logic [4:0]      r_tag;
  int r_ok, r_lat, r_rdy_cyc, r_flush_cyc, r_to_cyc, r_nflush, r_nvalid;

  core_pipe_exec_mdu_issue #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(g_clk_req), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .mdu_valid(mdu_valid), .mdu_op(mdu_op), .mdu_word(mdu_word),
    .mdu_rs1(mdu_rs1), .mdu_rs2(mdu_rs2), .mdu_flush(mdu_flush), .mdu_ready(mdu_ready),
    .mdu_rd(mdu_rd), .err_timeout(err_timeout)
  );

  always #5 g_clk = ~g_clk;

  // RISC-V M / Zbc result semantics, word variants for mul/div/divu/rem/remu
  function automatic logic [63:0] ref_result(logic [9:0] op, logic w, logic [63:0] a, logic [63:0] b);
    logic signed [127:0] sp;
    logic [127:0]        up, cl;
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  a32, b32;
    logic [31:0]         ua, ub, r32;
    logic [63:0]         r;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; ua = a[31:0]; ub = b[31:0];
    r = '0; r32 = '0; cl = '0;
    for (int i = 0; i < 64; i++) if (b[i]) cl = cl ^ ({64'd0, a} << i);
    if (w && (op[0] || op[6] || op[7] || op[8] || op[9])) begin
      if (op[0])      r32 = a32 * b32;
      else if (op[6]) r32 = (b32 == 0) ? 32'hFFFF_FFFF : (a32 == 32'sh8000_0000 && b32 == -32'sd1) ? a32 : a32 / b32;
      else if (op[7]) r32 = (ub == 0) ? 32'hFFFF_FFFF : ua / ub;
      else if (op[8]) r32 = (b32 == 0) ? a32 : (a32 == 32'sh8000_0000 && b32 == -32'sd1) ? 32'd0 : a32 % b32;
      else            r32 = (ub == 0) ? ua : ua % ub;
      r = {{32{r32[31]}}, r32};
    end else if (op[0]) r = a * b;
    else if (op[1]) begin sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = sp[127:64]; end
    else if (op[2]) begin up = {64'd0, a} * {64'd0, b}; r = up[127:64]; end
    else if (op[3]) begin sp = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = sp[127:64]; end
    else if (op[4]) r = cl[63:0];
    else if (op[5]) r = cl[127:64];
    else if (op[6]) r = (b == 0) ? '1 : (a == 64'h8000_0000_0000_0000 && sb == -64'sd1) ? a : 64'(sa / sb);
    else if (op[7]) r = (b == 0) ? '1 : a / b;
    else if (op[8]) r = (b == 0) ? a : (a == 64'h8000_0000_0000_0000 && sb == -64'sd1) ? 64'd0 : 64'(sa % sb);
    else if (op[9]) r = (b == 0) ? a : a % b;
    return r;
  endfunction

  // MDU stub: starts on mdu_valid, answers after stub_lat+2 cycles, holds until mdu_flush
  always @(posedge g_clk) begin
    if (!g_resetn || mdu_flush) begin
      stub_busy <= 1'b0; mdu_ready <= 1'b0; stub_cnt <= 0;
    end else if (mdu_valid && !stub_busy && !mdu_ready) begin
      stub_busy <= 1'b1; stub_cnt <= stub_lat;
    end else if (stub_busy && !stub_hang) begin
      if (stub_cnt == 0) begin
        stub_busy <= 1'b0; mdu_ready <= 1'b1;
        mdu_rd    <= ref_result(mdu_op, mdu_word, mdu_rs1, mdu_rs2);
      end else stub_cnt <= stub_cnt - 1;
    end
  end

  // One transaction; hold<0 leaves the response pending for the caller
  task automatic run_op(input logic [9:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag, input int hold);
    int guard;
    r_ok = 1; r_nflush = 0; r_nvalid = 0; r_rdy_cyc = -1; r_flush_cyc = -1; r_to_cyc = -1; r_lat = -1;
    req_op = op; req_word = w; req_rs1 = a; req_rs2 = b; req_tag = tag; req_valid = 1'b1;
    #1; guard = 0;
    while (!req_ready && guard < 200) begin @(negedge g_clk); guard++; end
    if (!req_ready) begin r_ok = 0; req_valid = 1'b0; return; end
    @(posedge g_clk); #1; req_valid = 1'b0;
    for (int c = 1; c <= TMO + 50; c++) begin
      @(negedge g_clk);
      if (mdu_flush) begin r_nflush++; if (r_flush_cyc < 0) r_flush_cyc = c; end
      if (mdu_valid) r_nvalid++;
      if (mdu_ready === 1'b1 && r_rdy_cyc < 0) r_rdy_cyc = c;
      if (err_timeout && r_to_cyc < 0) r_to_cyc = c;
      if (rsp_valid) begin r_lat = c; break; end
    end
    if (r_lat < 0) begin r_ok = 0; return; end
    r_data = rsp_data; r_err = rsp_err; r_tag = rsp_tag;
    if (hold >= 0) begin
      repeat (hold) @(negedge g_clk);
      rsp_ready = 1'b1; @(posedge g_clk); #1; rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1; g_resetn = 1'b0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    n_checks++; if ({rsp_valid, rsp_err, err_timeout, mdu_valid, mdu_flush, mdu_word} !== 6'b0) begin
      $display("FAIL reset_flags got=%b exp=000000", {rsp_valid, rsp_err, err_timeout, mdu_valid, mdu_flush, mdu_word}); end else n_pass++;
    n_checks++; if ({rsp_data, rsp_tag, mdu_op, mdu_rs1, mdu_rs2} !== '0) begin
      $display("FAIL reset_data got=%h/%h/%h/%h/%h exp=0", rsp_data, rsp_tag, mdu_op, mdu_rs1, mdu_rs2); end else n_pass++;
    n_checks++; if ({req_ready, g_clk_req} !== 2'b10) begin
      $display("FAIL reset_ready got=%b exp=10", {req_ready, g_clk_req}); end else n_pass++;
    @(posedge g_clk); #1; g_resetn = 1'b1;
  endtask

  task automatic test_mul_basic();
    stub_lat = 2;
    run_op(10'h001, 1'b0, 64'd7, 64'd6, 5'd3, 0);
    n_checks++; if (r_ok != 1) $display("FAIL mul_handshake got=timeout exp=response"); else n_pass++;
    n_checks++; if ({r_data, r_tag, r_err} !== {64'd42, 5'd3, 1'b0}) begin
      $display("FAIL mul_rsp got=%0d/%0d/%b exp=42/3/0", r_data, r_tag, r_err); end else n_pass++;
    n_checks++; if (r_nflush != 1 || r_flush_cyc != stub_lat + 3) begin
      $display("FAIL mul_flush got=%0d@%0d exp=1@%0d", r_nflush, r_flush_cyc, stub_lat + 3); end else n_pass++;
    n_checks++; if (r_lat != stub_lat + 4) $display("FAIL mul_latency got=%0d exp=%0d", r_lat, stub_lat + 4); else n_pass++;
  endtask

  task automatic test_back_to_back();
    stub_lat = 1;
    run_op(10'h080, 1'b0, 64'd100, 64'd7, 5'd5, 0);
    n_checks++; if ({r_ok[0], r_data} !== {1'b1, 64'd14}) $display("FAIL b2b_divu got=%0d exp=14", r_data); else n_pass++;
    @(negedge g_clk);
    n_checks++; if ({req_ready, mdu_valid, rsp_valid} !== 3'b100) begin
      $display("FAIL b2b_rearm got=%b exp=100", {req_ready, mdu_valid, rsp_valid}); end else n_pass++;
    run_op(10'h200, 1'b0, 64'd100, 64'd7, 5'd6, 0);
    n_checks++; if ({r_ok[0], r_data, r_tag} !== {1'b1, 64'd2, 5'd6}) $display("FAIL b2b_remu got=%0d/%0d exp=2/6", r_data, r_tag); else n_pass++;
  endtask

  task automatic test_stall();
    stub_lat = 0;
    run_op(10'h002, 1'b0, '1, '1, 5'd9, -1);
    n_checks++; if (r_ok != 1 || r_data !== 64'd0) $display("FAIL stall_mulh got=%h exp=0", r_data); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(posedge g_clk); #1; req_valid = 1'b1; req_op = 10'h001;
      @(negedge g_clk);
      n_checks++; if ({rsp_valid, rsp_data, rsp_tag, req_ready, g_clk_req} !== {1'b1, 64'd0, 5'd9, 1'b0, 1'b1}) begin
        $display("FAIL stall_hold cyc=%0d got=%b/%h/%0d/%b exp=1/0/9/0", i, rsp_valid, rsp_data, rsp_tag, req_ready); end else n_pass++;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge g_clk); #1; rsp_ready = 1'b0;
    @(negedge g_clk);
    n_checks++; if ({rsp_valid, mdu_valid, req_ready} !== 3'b001) begin
      $display("FAIL stall_release got=%b exp=001", {rsp_valid, mdu_valid, req_ready}); end else n_pass++;
  endtask

  task automatic test_flush();
    int seen;
    stub_lat = 6;
    req_op = 10'h040; req_rs1 = 64'd50; req_rs2 = 64'd3; req_tag = 5'd1; req_valid = 1'b1;
    @(posedge g_clk); #1; req_valid = 1'b0;
    repeat (2) begin @(posedge g_clk); #1; end
    flush = 1'b1;
    @(negedge g_clk);
    n_checks++; if ({mdu_valid, mdu_flush, req_ready} !== 3'b110) begin
      $display("FAIL flush_cycle got=%b exp=110", {mdu_valid, mdu_flush, req_ready}); end else n_pass++;
    @(posedge g_clk); #1; flush = 1'b0;
    seen = 0;
    repeat (8) begin @(negedge g_clk); if (rsp_valid || mdu_valid || !req_ready) seen++; end
    n_checks++; if (seen != 0) $display("FAIL flush_idle got=%0d busy cycles exp=0", seen); else n_pass++;
    stub_lat = 1;
    run_op(10'h001, 1'b0, 64'd5, 64'd5, 5'd2, 0);
    n_checks++; if ({r_ok[0], r_data, r_err} !== {1'b1, 64'd25, 1'b0}) $display("FAIL flush_next got=%0d exp=25", r_data); else n_pass++;
  endtask

  task automatic test_illegal();
    run_op(10'h003, 1'b0, 64'd9, 64'd9, 5'd12, 0);
    n_checks++; if ({r_ok[0], r_err, r_data, r_tag} !== {1'b1, 1'b1, 64'd0, 5'd12}) begin
      $display("FAIL illegal_rsp got=%b/%h/%0d exp=1/0/12", r_err, r_data, r_tag); end else n_pass++;
    n_checks++; if (r_lat != 1 || r_nvalid != 0) $display("FAIL illegal_timing got=%0d/%0d exp=1/0", r_lat, r_nvalid); else n_pass++;
    run_op(10'h000, 1'b0, 64'd1, 64'd1, 5'd13, 0);
    n_checks++; if ({r_err, r_data, r_nvalid} !== {1'b1, 64'd0, 32'd0}) $display("FAIL illegal_zero got=%b/%h exp=1/0", r_err, r_data); else n_pass++;
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 20));
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      default: return {32'd0, $urandom};
    endcase
  endfunction

  task automatic test_random();
    logic [9:0] op; logic w; logic [63:0] a, b, exp_d; logic [4:0] tag; bit legal; int idx;
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 9);
      op = 10'(10'd1 << idx); legal = 1'b1;
      if ($urandom_range(0, 9) == 0) begin op = 10'(10'h3 << $urandom_range(0, 8)); legal = 1'b0; end
      w = (legal && (idx == 0 || idx >= 6)) ? 1'($urandom_range(0, 1)) : 1'b0;
      a = pick_operand(); b = pick_operand(); tag = 5'($urandom_range(0, 31));
      stub_lat = $urandom_range(0, 5);
      exp_d = legal ? ref_result(op, w, a, b) : 64'd0;
      run_op(op, w, a, b, tag, $urandom_range(0, 3));
      n_checks++; if ({r_ok[0], r_data, r_err, r_tag} !== {1'b1, exp_d, !legal, tag}) begin
        $display("FAIL random_%0d op=%h w=%b a=%h b=%h got=%h/%b/%0d exp=%h/%b/%0d", i, op, w, a, b,
                 r_data, r_err, r_tag, exp_d, !legal, tag); end else n_pass++;
    end
  endtask

  task automatic test_timeout();
    stub_hang = 1'b1;
    run_op(10'h040, 1'b0, 64'd123, 64'd4, 5'd17, 0);
    stub_hang = 1'b0;
    n_checks++; if ({r_ok[0], r_err, r_data, r_tag} !== {1'b1, 1'b1, 64'd0, 5'd17}) begin
      $display("FAIL tmo_rsp got=%b/%h/%0d exp=1/0/17", r_err, r_data, r_tag); end else n_pass++;
    n_checks++; if (r_flush_cyc != TMO || r_nflush != 1 || r_nvalid != TMO) begin
      $display("FAIL tmo_flush got=%0d@%0d valid=%0d exp=1@%0d valid=%0d", r_nflush, r_flush_cyc, r_nvalid, TMO, TMO); end else n_pass++;
    n_checks++; if (r_to_cyc != TMO + 1 || r_lat != TMO + 1) begin
      $display("FAIL tmo_flag got=%0d/%0d exp=%0d", r_to_cyc, r_lat, TMO + 1); end else n_pass++;
    stub_lat = 0;
    run_op(10'h001, 1'b0, 64'd3, 64'd3, 5'd4, 0);
    @(negedge g_clk);
    n_checks++; if ({r_data, err_timeout} !== {64'd9, 1'b1}) $display("FAIL tmo_sticky got=%0d/%b exp=9/1", r_data, err_timeout); else n_pass++;
  endtask

`ifdef MDU_ISSUE_RESULT_CACHE_EN
  task automatic test_cache();
    stub_lat = 1;
    run_op(10'h001, 1'b0, 64'd7, 64'd6, 5'd3, 0);
    n_checks++; if (r_data !== 64'd42 || r_nvalid == 0) $display("FAIL cache_fill got=%0d/%0d exp=42/issued", r_data, r_nvalid); else n_pass++;
    run_op(10'h001, 1'b0, 64'd7, 64'd6, 5'd8, 0);
    n_checks++; if ({r_data, r_err, r_tag} !== {64'd42, 1'b0, 5'd8} || r_lat != 1 || r_nvalid != 0) begin
      $display("FAIL cache_hit got=%0d lat=%0d valid=%0d exp=42 lat=1 valid=0", r_data, r_lat, r_nvalid); end else n_pass++;
    run_op(10'h001, 1'b0, 64'd7, 64'd7, 5'd3, 0);
    n_checks++; if (r_data !== 64'd49 || r_nvalid == 0) $display("FAIL cache_miss got=%0d/%0d exp=49/issued", r_data, r_nvalid); else n_pass++;
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL global_timeout got=hung exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_mul_basic();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_random();
    test_timeout();
    test_reset();
`ifdef MDU_ISSUE_RESULT_CACHE_EN
    test_cache();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
